// File: rtl/mdu_pkg.sv
// Shared MDU operation codes, FSM state encoding and the divide helper
// used by the multiply/divide unit.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MFHI  = 3'd4;
   localparam logic [2:0] MDU_MFLO  = 3'd5;
   localparam logic [2:0] MDU_MTHI  = 3'd6;
   localparam logic [2:0] MDU_MTLO  = 3'd7;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_RUN  = 1'b1
   } mdu_state_e;

   // Returns {remainder, quotient}. Signed mode works on magnitudes so the
   // 0x80000000 / -1 case wraps to 0x80000000 instead of overflowing.
   function automatic logic [63:0] mdu_divide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        is_signed);
      logic [31:0] mag_a;
      logic [31:0] mag_b;
      logic [31:0] quo;
      logic [31:0] rem;
      logic        neg_q;
      logic        neg_r;
      neg_r = is_signed & a[31];
      neg_q = is_signed & (a[31] ^ b[31]);
      mag_a = neg_r ? (32'd0 - a) : a;
      mag_b = (is_signed & b[31]) ? (32'd0 - b) : b;
      if (mag_b == 32'd0) begin
         quo = 32'd0;
         rem = 32'd0;
      end else begin
         quo = mag_a / mag_b;
         rem = mag_a % mag_b;
      end
      if (neg_q) begin
         quo = 32'd0 - quo;
      end else begin
         quo = quo;
      end
      if (neg_r) begin
         rem = 32'd0 - rem;
      end else begin
         rem = rem;
      end
      return {rem, quo};
   endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at issue
// into pending registers and committed after a fixed latency modelled by a counter.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   mdu_state_e  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] phi_q, phi_d;
   logic [31:0] plo_q, plo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] smul_s;
   logic [63:0] umul_s;
   logic [63:0] sdiv_s;
   logic [63:0] udiv_s;

   assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign umul_s = {32'd0, A} * {32'd0, B};
   assign sdiv_s = mdu_divide(A, B, 1'b1);
   assign udiv_s = mdu_divide(A, B, 1'b0);

   assign Busy = (state_q == MDU_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

   // Next-state: issue in IDLE, count down in RUN, commit pending result on the last edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         MDU_IDLE: begin
            if (Start) begin
               case (MDUOp)
                  MDU_MULT: begin
                     state_d        = MDU_RUN;
                     cnt_d          = 32'(MULT_CYCLES);
                     {phi_d, plo_d} = smul_s;
                  end
                  MDU_MULTU: begin
                     state_d        = MDU_RUN;
                     cnt_d          = 32'(MULT_CYCLES);
                     {phi_d, plo_d} = umul_s;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state_d = MDU_RUN;
                     cnt_d   = 32'(DIV_CYCLES);
                     // A zero divisor still burns the latency but commits the current HI/LO back
                     if (B == 32'd0) begin
                        phi_d = hi_q;
                        plo_d = lo_q;
                     end else if (MDUOp == MDU_DIV) begin
                        {phi_d, plo_d} = sdiv_s;
                     end else begin
                        {phi_d, plo_d} = udiv_s;
                     end
                  end
                  MDU_MTHI: hi_d = A;
                  MDU_MTLO: lo_d = A;
                  default:  state_d = MDU_IDLE;
               endcase
            end else begin
               state_d = MDU_IDLE;
            end
         end
         MDU_RUN: begin
            if (cnt_q == 32'd1) begin
               hi_d    = phi_q;
               lo_d    = plo_q;
               cnt_d   = 32'd0;
               state_d = MDU_IDLE;
            end else begin
               cnt_d   = cnt_q - 32'd1;
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   // State, counter, pending and architectural registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Read port for mfhi/mflo
   always_comb begin
      MDUOut = 32'd0;
      case (MDUOp)
         MDU_MFHI: MDUOut = hi_q;
         MDU_MFLO: MDUOut = lo_q;
         default:  MDUOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected results computed with plain
// arithmetic, a monitor pops them whenever a Busy window closes.
module tb_mdu;
   import mdu_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   exp_t        exp_q[$];
   int          total_cnt = 0;
   int          pass_cnt  = 0;
   int          busy_cnt  = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] vis_hi = 32'd0;
   logic [31:0] vis_lo = 32'd0;

   mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
      .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                           input logic [31:0] old_hi, input logic [31:0] old_lo);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return {old_hi, old_lo};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Issue one op at a negedge; Start is held across exactly one rising edge.
   task automatic op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input bit ignored);
      exp_t        e;
      logic [63:0] r;
      MDUOp = code;
      A     = a;
      B     = b;
      Start = 1'b1;
      if (!ignored) begin
         case (code)
            MDU_MULT, MDU_MULTU: begin
               r = ref_mul(a, b, code == MDU_MULT);
               e.hi = r[63:32]; e.lo = r[31:0]; e.cycles = MULT_N;
               exp_q.push_back(e);
               m_hi = e.hi; m_lo = e.lo;
            end
            MDU_DIV, MDU_DIVU: begin
               r = ref_div(a, b, code == MDU_DIV, m_hi, m_lo);
               e.hi = r[63:32]; e.lo = r[31:0]; e.cycles = DIV_N;
               exp_q.push_back(e);
               m_hi = e.hi; m_lo = e.lo;
            end
            MDU_MTHI: begin m_hi = a; vis_hi = a; end
            MDU_MTLO: begin m_lo = a; vis_lo = a; end
            default: ;
         endcase
      end
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64; i++) begin
         if (!Busy) return;
         @(negedge clk);
      end
      total_cnt++;
      $display("FAIL wait_idle: Busy still high after 64 cycles");
   endtask

   task automatic read_check(input string name, input logic [2:0] code, input logic [31:0] exp);
      MDUOp = code;
      Start = 1'b0;
      #1;
      check(name, MDUOut, exp);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Monitor: HI/LO must hold during Busy; each closing Busy window pops one expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy_cnt = 0;
            exp_q.delete();
         end else if (Busy) begin
            busy_cnt++;
            check("hold_hi", HI, vis_hi);
            check("hold_lo", LO, vis_lo);
         end else if (busy_cnt != 0) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_completion: busy window of %0d with no queued op", busy_cnt);
            end else begin
               e = exp_q.pop_front();
               check("busy_len", 32'(busy_cnt), 32'(e.cycles));
               check("result_hi", HI, e.hi);
               check("result_lo", LO, e.lo);
               vis_hi = e.hi;
               vis_lo = e.lo;
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin
      logic [2:0]  code;
      logic [31:0] ra;
      logic [31:0] rb;
      reset = 1'b0;
      Start = 1'b0;
      A     = 32'd0;
      B     = 32'd0;
      MDUOp = MDU_MFHI;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, Busy}, 32'd0);
      check("reset_hi", HI, 32'd0);
      check("reset_lo", LO, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);   wait_idle();
      op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);  wait_idle();
      check("multu_hi", HI, 32'h0000_0001);
      op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);    wait_idle();
      check("div_lo", LO, 32'hFFFF_FFFD);
      op(MDU_DIVU, 32'd7, 32'd2, 1'b0);           wait_idle();
      op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
      check("ovf_lo", LO, 32'h8000_0000);

      // Divide by zero leaves HI/LO as written by mthi/mtlo
      op(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
      op(MDU_MTLO, 32'h5678, 32'd0, 1'b0);
      op(MDU_DIV, 32'd99, 32'd0, 1'b0);           wait_idle();
      read_check("div0_mfhi", MDU_MFHI, 32'h1234);
      read_check("div0_mflo", MDU_MFLO, 32'h5678);
      @(negedge clk);

      // Start during Busy is ignored
      op(MDU_MULT, 32'd3, 32'd4, 1'b0);
      op(MDU_MTLO, 32'hDEAD, 32'd0, 1'b1);
      wait_idle();
      check("ignored_mtlo_lo", LO, 32'd12);
      check("ignored_mtlo_hi", HI, 32'd0);

      // Back-to-back: read in first idle cycle, new DIVU issued the same cycle
      @(negedge clk);
      op(MDU_MULT, 32'd3, 32'd4, 1'b0);
      wait_idle();
      read_check("b2b_mflo", MDU_MFLO, 32'd12);
      op(MDU_DIVU, 32'd100, 32'd7, 1'b0);
      check("b2b_busy", {31'd0, Busy}, 32'd1);
      wait_idle();
      read_check("b2b_divu_mflo", MDU_MFLO, 32'd14);

      // Asynchronous reset mid-DIV
      @(negedge clk);
      op(MDU_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_reset_busy", {31'd0, Busy}, 32'd0);
      check("mid_reset_hi", HI, 32'd0);
      check("mid_reset_lo", LO, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0; vis_hi = 32'd0; vis_lo = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_reset_busy", {31'd0, Busy}, 32'd0);
      end
      check("post_reset_lo", LO, 32'd0);

      // Randomized phase
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0:       code = MDU_MULT;
            1:       code = MDU_MULTU;
            2:       code = MDU_DIV;
            3:       code = MDU_DIVU;
            4:       code = MDU_MTHI;
            default: code = MDU_MTLO;
         endcase
         ra = rnd_operand();
         rb = rnd_operand();
         op(code, ra, rb, 1'b0);
         wait_idle();
         if ($urandom_range(0, 2) == 0) begin
            read_check("rnd_mfhi", MDU_MFHI, m_hi);
            read_check("rnd_mflo", MDU_MFLO, m_lo);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
